seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port q_high  input  4  BCD tenths-of-frame high digit from the stopwatch counter.
REQ-005 SHALL have port q_low  input  4  BCD low digit from the stopwatch counter.
REQ-006 SHALL have port en  input  1  scan enable; 0 turns the display off and holds scan state.
REQ-007 SHALL have port freeze  input  1  1 holds the displayed snapshot (lap hold).
REQ-008 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an_n  output  2  digit anodes, bit0 = low digit, bit1 = high digit, active-low.
REQ-010 SHALL have port dp_n  output  1  decimal point, active-low.

Function
REQ-011 SHALL keep divider cnt (0..DIV-1) that increments each cycle with en=1 and holds with en=0.
REQ-012 SHALL define tick as cnt==DIV-1 with en=1; on tick cnt wraps to 0 and digit index idx toggles (0 low, 1 high).
REQ-013 SHALL hold snapshot registers snap_high/snap_low; loaded from q_high/q_low on a tick with idx==1 (frame end) and freeze=0.
REQ-014 SHALL not load the snapshot when freeze=1, including freeze asserted in the same cycle as frame end; scanning continues.
REQ-015 SHALL register all outputs; outputs reflect idx/snapshot state one cycle after that state changes (1-cycle latency).
REQ-016 SHALL drive, with en=1, an_n = 2'b10 when idx=0 and 2'b01 when idx=1; never both low.
REQ-017 SHALL drive, with en=0, an_n=2'b11, seg_n=7'h7F, dp_n=1 from the next cycle on.
REQ-018 SHALL decode digit 0..9 with the standard 7-segment patterns (e.g. 0 -> 7'h40, 8 -> 7'h00, 1 -> 7'h79).
REQ-019 SHALL decode nibble values 10..15 as dash: seg_n=7'h3F (g only lit).
REQ-020 SHALL light dp (dp_n=0) while the high digit is displayed, dp_n=1 otherwise.
REQ-021 SHALL change seg_n and an_n in the same clock edge, so no cycle shows one digit's segments on the other anode.
REQ-022 SHALL show the snapshot only, never the live inputs, so a frame never mixes values from two counter states.

Reset
REQ-023 SHALL on RST=1 set cnt=0, idx=0, snap_high=0, snap_low=0, an_n=2'b11, seg_n=7'h7F, dp_n=1.
REQ-024 SHALL give RST priority over en and freeze; reset mid-frame aborts the frame with no residual snapshot.
REQ-025 SHALL show the low digit of snapshot 0 one cycle after the first edge with RST=0 and en=1.

Configuration
REQ-026 SHALL support macro SEG7_LZB_EN (leading-zero blanking).
REQ-027 SHALL, with SEG7_LZB_EN defined, drive seg_n=7'h7F during the high slot when snap_high==0; an_n and dp_n behave as normal.
REQ-028 SHALL, without SEG7_LZB_EN, display snap_high==0 as digit 0 (7'h40).

Verification
REQ-029 Reset, DIV=4, en=1, q_high=3, q_low=7 -> after one frame, slots alternate every 4 cycles: an_n=10 seg_n=7'h78 dp_n=1 / an_n=01 seg_n=7'h30 dp_n=0.
REQ-030 Inputs change 5->6 mid-frame (during low slot) -> displayed digits stay old until the frame-end tick, then both update together.
REQ-031 freeze=1 held over 3 frames while q_low counts 0..9 -> display constant; freeze=0 -> new value appears after the next frame end.
REQ-032 q_high=0: with SEG7_LZB_EN high slot seg_n=7'h7F dp_n=0; without it seg_n=7'h40; q_low=12 -> low slot seg_n=7'h3F.
REQ-033 en=0 for 10 cycles mid-slot -> outputs off next cycle, cnt/idx frozen; en=1 -> same slot resumes for its remaining cycles.
REQ-034 RST=1 pulse during high slot -> next cycle all outputs off; after release, low digit of snapshot 0 (7'h40) displayed.

Source files
------------

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - two-digit multiplexed 7-segment scanner with frame snapshot
// Optional leading-zero blanking of the high digit: define SEG7_LZB_EN.
module seg7_scan #(
    parameter int unsigned DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] q_high,
    input  logic [3:0] q_low,
    input  logic       en,
    input  logic       freeze,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       dp_n
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] r_cnt;
    logic        r_idx;
    logic [3:0]  r_snap_high;
    logic [3:0]  r_snap_low;
    logic [6:0]  r_seg_n;
    logic [1:0]  r_an_n;
    logic        r_dp_n;

    logic        w_tick;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg;

    assign w_tick  = en && (r_cnt == LAST);
    assign w_digit = r_idx ? r_snap_high : r_snap_low;

    // Patterns are {g,f,e,d,c,b,a}, active-low; non-BCD nibbles show a dash.
    always_comb begin
        w_seg = 7'h3F;
        case (w_digit)
            4'd0: w_seg = 7'h40;
            4'd1: w_seg = 7'h79;
            4'd2: w_seg = 7'h24;
            4'd3: w_seg = 7'h30;
            4'd4: w_seg = 7'h19;
            4'd5: w_seg = 7'h12;
            4'd6: w_seg = 7'h02;
            4'd7: w_seg = 7'h78;
            4'd8: w_seg = 7'h00;
            4'd9: w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase
`ifdef SEG7_LZB_EN
        if (r_idx && (r_snap_high == 4'd0)) begin
            w_seg = 7'h7F;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= '0;
            r_idx       <= 1'b0;
            r_snap_high <= '0;
            r_snap_low  <= '0;
            r_seg_n     <= 7'h7F;
            r_an_n      <= 2'b11;
            r_dp_n      <= 1'b1;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= ~r_idx;
                // Frame end: capture both digits together so a frame never mixes counter states.
                if (r_idx && !freeze) begin
                    r_snap_high <= q_high;
                    r_snap_low  <= q_low;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_an_n  <= r_idx ? 2'b01 : 2'b10;
            r_seg_n <= w_seg;
            r_dp_n  <= ~r_idx;
        end else begin
            r_seg_n <= 7'h7F;
            r_an_n  <= 2'b11;
            r_dp_n  <= 1'b1;
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;
    assign dp_n  = r_dp_n;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan
module tb_seg7_scan;

    localparam int DIV = 4;
`ifdef SEG7_LZB_EN
    localparam logic [6:0] HZERO = 7'h7F;
`else
    localparam logic [6:0] HZERO = 7'h40;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] q_high = 4'd0;
    logic [3:0] q_low = 4'd0;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       dp_n;

    int tests = 0;
    int fails = 0;

    seg7_scan #(.DIV(DIV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .q_high(q_high),
        .q_low (q_low),
        .en    (en),
        .freeze(freeze),
        .seg_n (seg_n),
        .an_n  (an_n),
        .dp_n  (dp_n)
    );

    always #5 CLK = ~CLK;

    // Reference: enabled cycles since reset, modulo one frame (two slots of DIV cycles).
    int         m_n = 0;
    logic [3:0] m_sh = 4'd0;
    logic [3:0] m_sl = 4'd0;
    logic [6:0] m_seg = 7'h7F;
    logic [1:0] m_an = 2'b11;
    logic       m_dp = 1'b1;

    function automatic logic [6:0] glyph(input logic [3:0] v, input bit high);
        logic [6:0] lit;
        case (v)
            4'd0: lit = 7'h3F;
            4'd1: lit = 7'h06;
            4'd2: lit = 7'h5B;
            4'd3: lit = 7'h4F;
            4'd4: lit = 7'h66;
            4'd5: lit = 7'h6D;
            4'd6: lit = 7'h7D;
            4'd7: lit = 7'h07;
            4'd8: lit = 7'h7F;
            4'd9: lit = 7'h6F;
            default: lit = 7'h40;
        endcase
`ifdef SEG7_LZB_EN
        if (high && v == 4'd0) lit = 7'h00;
`endif
        return ~lit;
    endfunction

    task automatic cycle(input string tag);
        bit high;
        @(posedge CLK);
        if (RST) begin
            m_n = 0; m_sh = 4'd0; m_sl = 4'd0;
            m_seg = 7'h7F; m_an = 2'b11; m_dp = 1'b1;
        end else if (!en) begin
            m_seg = 7'h7F; m_an = 2'b11; m_dp = 1'b1;
        end else begin
            high  = ((m_n / DIV) % 2) == 1;
            m_an  = high ? 2'b01 : 2'b10;
            m_dp  = !high;
            m_seg = glyph(high ? m_sh : m_sl, high);
            if (m_n == 2 * DIV - 1 && !freeze) begin
                m_sh = q_high;
                m_sl = q_low;
            end
            m_n = (m_n + 1) % (2 * DIV);
        end
        #1;
        tests++;
        if ({seg_n, an_n, dp_n} !== {m_seg, m_an, m_dp}) begin
            fails++;
            $display("FAIL %s t=%0t: got seg_n=%h an_n=%b dp_n=%b, want seg_n=%h an_n=%b dp_n=%b",
                     tag, $time, seg_n, an_n, dp_n, m_seg, m_an, m_dp);
        end
        tests++;
        if (an_n === 2'b00) begin
            fails++;
            $display("FAIL %s both_anodes t=%0t: got an_n=%b, want not 00", tag, $time, an_n);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       frz;
        logic [3:0] qh;
        logic [3:0] ql;
        logic [6:0] seg;
        logic [1:0] an;
        logic       dp;
    } vec_t;

    vec_t vt[18];

    initial begin
        // Reset, then one frame of snapshot 0, then 3/7 from the first frame-end load.
        vt[0] = '{1'b1, 1'b1, 1'b0, 4'd3, 4'd7, 7'h7F, 2'b11, 1'b1};
        for (int i = 1; i <= 4; i++)  vt[i] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 7'h40, 2'b10, 1'b1};
        for (int i = 5; i <= 8; i++)  vt[i] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, HZERO, 2'b01, 1'b0};
        for (int i = 9; i <= 12; i++) vt[i] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 7'h78, 2'b10, 1'b1};
        for (int i = 13; i <= 16; i++) vt[i] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 7'h30, 2'b01, 1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 7'h78, 2'b10, 1'b1};

        for (int i = 0; i < 18; i++) begin
            RST = vt[i].rst; en = vt[i].en; freeze = vt[i].frz;
            q_high = vt[i].qh; q_low = vt[i].ql;
            cycle("table_model");
            tests++;
            if ({seg_n, an_n, dp_n} !== {vt[i].seg, vt[i].an, vt[i].dp}) begin
                fails++;
                $display("FAIL table[%0d]: got seg_n=%h an_n=%b dp_n=%b, want seg_n=%h an_n=%b dp_n=%b",
                         i, seg_n, an_n, dp_n, vt[i].seg, vt[i].an, vt[i].dp);
            end
        end

        // Mid-frame input change during the low slot.
        q_high = 4'd5; q_low = 4'd5;
        run(2 * DIV * 2, "mid_frame_setup");
        run(1, "mid_frame_low");
        q_high = 4'd6; q_low = 4'd6;
        run(2 * DIV * 2, "mid_frame_change");

        // Lap hold over three frames while the low digit counts.
        freeze = 1'b1;
        for (int i = 0; i < 3 * 2 * DIV; i++) begin
            q_low = 4'((i / 2) % 10);
            cycle("freeze_hold");
        end
        freeze = 1'b0;
        q_low = 4'd9;
        run(2 * DIV * 2, "freeze_release");

        // Leading zero in the high digit and a dash in the low digit.
        q_high = 4'd0; q_low = 4'd12;
        run(2 * DIV * 2, "zero_dash");

        // Enable dropped mid-slot for ten cycles.
        q_high = 4'd2; q_low = 4'd4;
        run(2 * DIV + 1, "en_pre");
        en = 1'b0;
        run(10, "en_off");
        en = 1'b1;
        run(2 * DIV * 2, "en_resume");

        // Reset pulse while the high digit is on.
        while (m_n < DIV + 1) cycle("rst_align");
        RST = 1'b1;
        cycle("rst_pulse");
        RST = 1'b0;
        run(2 * DIV * 2, "rst_release");

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            RST    = ($urandom_range(0, 99) < 2);
            en     = ($urandom_range(0, 99) < 85);
            freeze = ($urandom_range(0, 99) < 20);
            q_high = 4'($urandom_range(0, 15));
            q_low  = 4'($urandom_range(0, 15));
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
